// File: rtl/uart_tx_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Holds the FSM state encoding, the byte type and a one-hot to index helper.
package uart_tx_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GO,
        ST_WAIT_ACK,
        ST_WAIT_DONE
    } state_t;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_MAX_BURST   = 16;
    localparam int DEF_ACK_TIMEOUT = 64;

    // Up to 8 requesters; callers truncate the result to their pointer width.
    function automatic logic [2:0] oh_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++)
            if (oh[i]) idx = 3'(i);
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority pick: first valid requester searching upward from i_ptr+1.
// Purely combinational; the owner of the pointer decides when to move it.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_valid,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic          o_any
);

    logic          w_found;
    logic [PW-1:0] w_idx;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 1; i <= N; i++) begin
            w_idx = PW'((int'(i_ptr) + i) % N);
            if (!w_found && i_valid[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

    assign o_any = |i_valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte streams: round-robin grant,
// one XMitGo per byte paced on TxEmpty, release on packet end or burst limit.
module uart_tx_arbiter
    import uart_tx_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int MAX_BURST   = DEF_MAX_BURST,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                 Clock,
    input  logic                 ResetN,
    input  logic [NUM_REQ-1:0]   ReqValid,
    input  logic [NUM_REQ*8-1:0] ReqData,
    input  logic [NUM_REQ-1:0]   ReqLast,
    output logic [NUM_REQ-1:0]   ReqReady,
    input  logic                 TxEmpty,
    output logic                 XMitGo,
    output byte_t                TxData,
    output logic [NUM_REQ-1:0]   Grant,
    output logic                 Busy,
    output logic                 AckTimeoutErr
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    state_t             r_state, w_next;
    logic [NUM_REQ-1:0] r_grant, r_ready;
    logic [PW-1:0]      r_ptr;
    byte_t              r_txdata;
    logic               r_last;
    logic [BW-1:0]      r_burst;
    logic [TW-1:0]      r_tcnt;

    logic [NUM_REQ-1:0] w_pick;
    logic               w_any;
    logic [PW-1:0]      w_gidx;
    logic               w_sel_valid, w_sel_last;
    byte_t              w_sel_data;
    logic               w_do_grant, w_do_load, w_release, w_timeout;

    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
        .i_valid (ReqValid),
        .i_ptr   (r_ptr),
        .o_grant (w_pick),
        .o_any   (w_any)
    );

    // Only the granted lane is looked at; everything else is masked off.
    assign w_sel_valid = |(ReqValid & r_grant);
    assign w_sel_last  = |(ReqLast & r_grant);
    assign w_gidx      = PW'(oh_to_idx(8'(r_grant)));

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (r_grant[i]) w_sel_data = w_sel_data | ReqData[8*i +: 8];
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_do_grant = 1'b0;
        w_do_load  = 1'b0;
        w_release  = 1'b0;
        w_timeout  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_do_grant = 1'b1;
                    w_next     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_sel_valid && TxEmpty) begin
                    w_do_load = 1'b1;
                    w_next    = ST_GO;
                end
            end
            ST_GO: w_next = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                // r_tcnt is 0 in the first WAIT_ACK cycle, so the last allowed cycle is ACK_TIMEOUT-1.
                if (!TxEmpty) begin
                    w_next = ST_WAIT_DONE;
                end else if (r_tcnt == TW'(ACK_TIMEOUT - 1)) begin
                    w_timeout = 1'b1;
                    w_next    = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (TxEmpty) begin
                    if (r_last || r_burst == BW'(MAX_BURST)) begin
                        w_release = 1'b1;
                        w_next    = ST_IDLE;
                    end else begin
                        w_next = ST_LOAD;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_grant  <= '0;
            r_ready  <= '0;
            r_ptr    <= PW'(NUM_REQ - 1);
            r_txdata <= '0;
            r_last   <= 1'b0;
            r_burst  <= '0;
            r_tcnt   <= '0;
        end else begin
            r_ready <= '0;
            if (w_do_grant) begin
                r_grant <= w_pick;
                r_burst <= '0;
            end
            if (w_do_load) begin
                r_txdata <= w_sel_data;
                r_ready  <= r_grant;
                r_last   <= w_sel_last;
                r_burst  <= r_burst + BW'(1);
            end
            if (r_state == ST_GO)            r_tcnt <= '0;
            else if (r_state == ST_WAIT_ACK) r_tcnt <= r_tcnt + TW'(1);
            if (w_release) begin
                r_ptr   <= w_gidx;
                r_grant <= '0;
            end
        end
    end

    assign ReqReady      = r_ready;
    assign XMitGo        = (r_state == ST_GO);
    assign TxData        = r_txdata;
    assign Grant         = r_grant;
    assign Busy          = (r_state != ST_IDLE);
    assign AckTimeoutErr = w_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: byte-queue requesters and a simple TX
// core model driven on the falling edge, outputs logged and checked against hand values.
module tb_uart_tx_arbiter;

    localparam int NR = 4;

    logic            Clock   = 1'b0;
    logic            ResetN  = 1'b1;
    logic [NR-1:0]   ReqValid = '0;
    logic [NR*8-1:0] ReqData  = '0;
    logic [NR-1:0]   ReqLast  = '0;
    logic            TxEmpty  = 1'b1;
    logic [NR-1:0]   ReqReady, Grant;
    logic            XMitGo, Busy, AckTimeoutErr;
    logic [7:0]      TxData;

    always #5 Clock = ~Clock;

    uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(4), .ACK_TIMEOUT(8)) dut (
        .Clock         (Clock),
        .ResetN        (ResetN),
        .ReqValid      (ReqValid),
        .ReqData       (ReqData),
        .ReqLast       (ReqLast),
        .ReqReady      (ReqReady),
        .TxEmpty       (TxEmpty),
        .XMitGo        (XMitGo),
        .TxData        (TxData),
        .Grant         (Grant),
        .Busy          (Busy),
        .AckTimeoutErr (AckTimeoutErr)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // requester byte queues: {last, data}
    logic [8:0] rmem [NR][64];
    int rhead [NR] = '{default: 0};
    int rtail [NR] = '{default: 0};

    // logs
    logic [7:0] xm_data [$];
    logic [3:0] xm_gnt  [$];
    int         xm_cyc  [$];
    int         te_cyc  [$];
    int         g_idx   [$];
    int         g_gap   [$];
    int cyc = 0, rr_cyc = 0, rr_n = 0, rr_bad = 0, rise_cyc = -100, zrun = 0, tx_cnt = 0;
    logic [3:0] prev_g = '0;
    int   tx_mode  = 0;
    logic tx_force = 1'b1;

    logic [7:0] e3d [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h3C, 8'h05,
                             8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B};
    logic [3:0] e3g [12] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h8, 4'h1,
                             4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1};

    always @(negedge Clock) begin
        cyc++;
        if (XMitGo) begin
            xm_data.push_back(TxData);
            xm_gnt.push_back(Grant);
            xm_cyc.push_back(cyc);
        end
        if (AckTimeoutErr) te_cyc.push_back(cyc);
        if (ReqReady != '0) begin
            rr_cyc = cyc;
            rr_n++;
            if ((ReqReady & ~Grant) != '0 || !$onehot(ReqReady)) rr_bad++;
        end
        if (Grant == '0) zrun++;
        else if (prev_g == '0) begin
            for (int i = 0; i < NR; i++)
                if (Grant[i]) g_idx.push_back(i);
            g_gap.push_back(zrun);
            zrun = 0;
        end
        prev_g = Grant;
        for (int i = 0; i < NR; i++) begin
            if (ReqReady[i]) rhead[i]++;
            ReqValid[i]      = rhead[i] < rtail[i];
            ReqData[8*i +: 8] = rmem[i][rhead[i]][7:0];
            ReqLast[i]       = rmem[i][rhead[i]][8];
        end
        // TX core: forced level, or drop 2 cycles after XMitGo and rise 20 later
        if (tx_mode == 0) begin
            if (!TxEmpty && tx_force) rise_cyc = cyc;
            TxEmpty = tx_force;
        end else if (!ResetN) begin
            tx_cnt  = 0;
            TxEmpty = 1'b1;
        end else if (XMitGo) begin
            tx_cnt = 1;
        end else if (tx_cnt > 0) begin
            tx_cnt++;
            if (tx_cnt == 3) TxEmpty = 1'b0;
            if (tx_cnt == 23) begin
                TxEmpty = 1'b1;
                tx_cnt  = 0;
            end
        end
    end

    task automatic push(input int r, input logic [7:0] d, input logic l);
        rmem[r][rtail[r]] = {l, d};
        rtail[r]++;
    endtask

    task automatic step();
        @(posedge Clock);
        #2;
    endtask

    function automatic bit drained();
        bit d;
        d = 1'b1;
        for (int i = 0; i < NR; i++)
            if (rhead[i] != rtail[i]) d = 1'b0;
        return d;
    endfunction

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        do begin step(); n++; end while (!(drained() && !Busy) && n < 3000);
        chk({tag, "_drain"}, 32'(n < 3000), 32'd1);
    endtask

    task automatic wait_xm(input int target, input string tag);
        int n;
        n = 0;
        while (xm_data.size() < target && n < 3000) begin step(); n++; end
        chk({tag, "_xm"}, 32'(n < 3000), 32'd1);
    endtask

    initial begin
        int b, g0, te0, rrn0, n;

        // asynchronous reset, checked before any clock edge
        #1 ResetN = 1'b0;
        #2;
        chk("rst_grant", Grant, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_xmitgo", XMitGo, 0);
        chk("rst_ready", ReqReady, 0);
        chk("rst_txdata", TxData, 0);
        chk("rst_tout", AckTimeoutErr, 0);
        repeat (2) @(negedge Clock);
        ResetN = 1'b1;
        step();

        // 1: single packet from req0
        tx_mode = 1;
        b = xm_data.size(); g0 = g_idx.size();
        push(0, 8'h48, 0); push(0, 8'h69, 0); push(0, 8'h0A, 1);
        wait_drain("t1");
        chk("t1_nbytes", xm_data.size() - b, 3);
        chk("t1_b0", xm_data[b], 8'h48);
        chk("t1_b1", xm_data[b+1], 8'h69);
        chk("t1_b2", xm_data[b+2], 8'h0A);
        for (int i = 0; i < 3; i++) chk("t1_gnt", xm_gnt[b+i], 4'b0001);
        chk("t1_ngrants", g_idx.size() - g0, 1);
        chk("t1_gidx", g_idx[g0], 0);
        chk("t1_grant_after", Grant, 0);
        chk("t1_busy_after", Busy, 0);

        // 2: req1/req2 alternating single-byte packets
        b = xm_data.size(); g0 = g_idx.size();
        push(1, 8'hA1, 1); push(1, 8'hA2, 1);
        push(2, 8'hB1, 1); push(2, 8'hB2, 1);
        wait_drain("t2");
        chk("t2_g0", g_idx[g0], 1);
        chk("t2_g1", g_idx[g0+1], 2);
        chk("t2_g2", g_idx[g0+2], 1);
        chk("t2_g3", g_idx[g0+3], 2);
        for (int i = 1; i < 4; i++) chk("t2_idle_gap", g_gap[g0+i], 1);
        chk("t2_d0", xm_data[b], 8'hA1);
        chk("t2_d1", xm_data[b+1], 8'hB1);
        chk("t2_d2", xm_data[b+2], 8'hA2);
        chk("t2_d3", xm_data[b+3], 8'hB2);

        // 3: burst limit of 4 forces req0 to yield to req3
        b = xm_data.size(); g0 = g_idx.size();
        for (int i = 1; i <= 10; i++) push(0, 8'(i), 0);
        n = 0;
        while (Grant != 4'b0001 && n < 500) begin step(); n++; end
        chk("t3_grant0", Grant, 4'b0001);
        push(3, 8'h3C, 1);
        wait_xm(b + 10, "t3");
        push(0, 8'h0B, 1);
        wait_drain("t3");
        chk("t3_nbytes", xm_data.size() - b, 12);
        for (int i = 0; i < 12; i++) begin
            chk("t3_data", xm_data[b+i], e3d[i]);
            chk("t3_gnt", xm_gnt[b+i], e3g[i]);
        end
        chk("t3_gseq1", g_idx[g0+1], 3);
        chk("t3_gseq2", g_idx[g0+2], 0);

        // 4: TxEmpty never falls -> timeout 8 cycles after each XMitGo
        tx_mode = 0; tx_force = 1'b1;
        step();
        b = xm_data.size(); te0 = te_cyc.size();
        push(0, 8'hC1, 0); push(0, 8'hC2, 1);
        wait_drain("t4");
        chk("t4_nbytes", xm_data.size() - b, 2);
        chk("t4_ntout", te_cyc.size() - te0, 2);
        chk("t4_lat0", te_cyc[te0] - xm_cyc[b], 8);
        chk("t4_lat1", te_cyc[te0+1] - xm_cyc[b+1], 8);
        chk("t4_d1", xm_data[b+1], 8'hC2);

        // 5: grant issued while TxEmpty low; load waits for it
        tx_force = 1'b0;
        repeat (2) step();
        rrn0 = rr_n; b = xm_data.size();
        push(1, 8'h55, 1);
        repeat (10) step();
        chk("t5_grant", Grant, 4'b0010);
        chk("t5_no_ready", rr_n - rrn0, 0);
        chk("t5_no_go", xm_data.size() - b, 0);
        tx_force = 1'b1;
        wait_drain("t5");
        chk("t5_ready_lat", rr_cyc - rise_cyc, 1);
        chk("t5_data", xm_data[b], 8'h55);

        // 6: async reset in WAIT_DONE, then pointer restarts at req0
        tx_mode = 1;
        b = xm_data.size();
        push(0, 8'h11, 0); push(0, 8'h22, 1);
        wait_xm(b + 1, "t6");
        repeat (5) step();
        chk("t6_busy_pre", Busy, 1);
        @(negedge Clock);
        #2 ResetN = 1'b0;
        #1;
        chk("t6_rst_grant", Grant, 0);
        chk("t6_rst_busy", Busy, 0);
        chk("t6_rst_txdata", TxData, 0);
        chk("t6_rst_go", XMitGo, 0);
        g0 = g_idx.size(); b = xm_data.size();
        push(2, 8'h33, 1);
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        ResetN = 1'b1;
        wait_drain("t6");
        chk("t6_first", g_idx[g0], 0);
        chk("t6_second", g_idx[g0+1], 2);
        chk("t6_d0", xm_data[b], 8'h22);
        chk("t6_d1", xm_data[b+1], 8'h33);

        chk("ready_only_granted", rr_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d passed so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule
